mem_arbiter: RTL and testbench

- Shares the single physical-memory port between the instruction cache (fetch side) and the data cache (mem stage: loads, stores, LDI/STI indirect accesses).
- Grants one requester per transaction and holds the grant until pmem_resp. Routes address, control and write data from the owner to memory, and returns resp only to the owner.
- The dcache has priority because it carries the older instruction. A starvation counter guarantees icache forward progress.

---
 rtl/mem_arbiter_pkg.sv | 46 ++++
 rtl/mem_arbiter_ctrl.sv | 84 ++++++++
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types and constants for the physical-memory arbiter.
//                Provides the cache-line type, the arbiter state encoding
//                and the owner codes reported on arb_owner.
//  Contents    : lc3b_word / lc3b_line   - address and line data types
//                arb_state_t             - arbiter FSM states
//                ARB_NONE/ARB_I/ARB_D    - owner codes
//                owner_of()              - state to owner code mapping
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int LC3B_WORD_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_WORD_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  // The state values are chosen to match the owner codes, so the
  // owner output needs no decode beyond a cast.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_SERVE_I = 2'b01,
    ARB_SERVE_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] ARB_NONE = 2'b00;
  localparam logic [1:0] ARB_I    = 2'b01;
  localparam logic [1:0] ARB_D    = 2'b10;

  // Map an arbiter state onto the owner code; any unexpected encoding
  // reports no owner.
  function automatic logic [1:0] owner_of(input arb_state_t s);
    logic [1:0] o;
    case (s)
      ARB_SERVE_I: o = ARB_I;
      ARB_SERVE_D: o = ARB_D;
      default:     o = ARB_NONE;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_ctrl
//  Description : Arbitration FSM for the shared memory port. Chooses the next
//                owner in IDLE (dcache preferred, icache forced after
//                STARVE_LIMIT consecutive losses), holds the grant until
//                pmem_resp and returns to IDLE for one bubble cycle.
//  Ports       : clk         in   system clock
//                rst_n       in   synchronous active-low reset
//                icache_req  in   icache has a request pending
//                dcache_req  in   dcache has a read or write pending
//                pmem_resp   in   memory completed the current transaction
//                state       out  current arbiter state
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_ctrl
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       icache_req,
  input  logic       dcache_req,
  input  logic       pmem_resp,
  output arb_state_t state
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state_q;
  arb_state_t state_d;
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ARB_IDLE: begin
        // The counter only tracks losses while the icache is actually
        // waiting; an idle cycle without an icache request forgets history.
        if (!icache_req) begin
          starve_d = 4'd0;
        end
        if (icache_req && (!dcache_req || (starve_q >= LIMIT))) begin
          state_d  = ARB_SERVE_I;
          starve_d = 4'd0;
        end else if (dcache_req) begin
          state_d = ARB_SERVE_D;
          if (icache_req && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      // The grant is held until memory answers, even if the owner has
      // dropped its request in the meantime.
      ARB_SERVE_I,
      ARB_SERVE_D: begin
        if (pmem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        starve_d = 4'd0;
      end
    endcase
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one physical-memory port between the icache (fetch)
//                and the dcache (loads, stores, LDI/STI). One owner per
//                transaction; the grant is held until pmem_resp. Request,
//                address and write data are routed from the owner, and the
//                response strobe is returned only to the owner.
//  Ports       : clk, rst_n                     clock, sync active-low reset
//                icache_pmem_read/address       icache line-fill request
//                icache_pmem_rdata/resp         icache fill data / done
//                dcache_pmem_read/write         dcache fill / writeback
//                dcache_pmem_address/wdata      dcache address / wb data
//                dcache_pmem_rdata/resp         dcache fill data / done
//                pmem_read/write/address/wdata  to physical memory
//                pmem_rdata/resp                from physical memory
//                arb_owner                      00 none, 01 icache, 10 dcache
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned LINE_W       = 128,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        arb_owner
);

  arb_state_t state;
  logic       dcache_req;

  assign dcache_req = dcache_pmem_read | dcache_pmem_write;

  mem_arbiter_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .icache_req (icache_pmem_read),
    .dcache_req (dcache_req),
    .pmem_resp  (pmem_resp),
    .state      (state)
  );

  // Memory-side mux: purely combinational from the registered state so the
  // request reaches memory in the cycle after the grant decision. IDLE
  // drives an all-zero bus.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      ARB_SERVE_I: begin
        pmem_read    = icache_pmem_read;
        pmem_address = icache_pmem_address;
      end
      ARB_SERVE_D: begin
        pmem_read    = dcache_pmem_read;
        pmem_write   = dcache_pmem_write;
        pmem_address = dcache_pmem_address;
        pmem_wdata   = dcache_pmem_wdata;
      end
      default: begin
      end
    endcase
  end

  // A response seen while IDLE (e.g. a late answer to a transaction
  // abandoned by reset) reaches neither cache.
  assign icache_pmem_resp = pmem_resp & (state == ARB_SERVE_I);
  assign dcache_pmem_resp = pmem_resp & (state == ARB_SERVE_D);

  // Read data is qualified by resp on the cache side, so it is broadcast.
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  assign arb_owner = owner_of(state);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Directed scenarios
//                followed by randomized request traffic compared against a
//                transaction-level arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  localparam int LIMIT  = 4;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_address;
  logic [LINE_W-1:0] icache_pmem_rdata;
  logic              icache_pmem_resp;
  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_address;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic [LINE_W-1:0] dcache_pmem_rdata;
  logic              dcache_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [1:0]        arb_owner;

  int checks = 0;
  int errors = 0;
  // Model: number of arbitrations the icache has lost in a row while waiting.
  int lost   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W       (ADDR_W),
    .LINE_W       (LINE_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp),
    .arb_owner           (arb_owner)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    pmem_rdata          = '0;
    pmem_resp           = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    lost  = 0;
  endtask

  // Winner of an arbitration, from the priority and anti-starvation rules.
  function automatic logic [1:0] pick(input bit ireq, input bit dreq, input int nlost);
    if (ireq && dreq) return (nlost >= LIMIT) ? OWN_I : OWN_D;
    if (dreq)         return OWN_D;
    if (ireq)         return OWN_I;
    return OWN_NONE;
  endfunction

  function automatic int next_lost(input bit ireq, input logic [1:0] win, input int nlost);
    if (!ireq)        return 0;
    if (win == OWN_I) return 0;
    if (win == OWN_D) return nlost + 1;
    return nlost;
  endfunction

  initial begin
    bit               ipend;
    bit               dpend;
    bit               dwr;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] da;
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] rd;
    logic [1:0]        win;
    int                lat;
    int                first_i;

    // ---------------- reset with both requests high ----------------
    rst_n = 1'b0;
    clear_inputs();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1111;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2222;
    pmem_resp           = 1'b1;
    cyc();
    cyc();
    chk("rst_pmem_read",  pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_iresp",      icache_pmem_resp, 0);
    chk("rst_dresp",      dcache_pmem_resp, 0);
    chk("rst_owner",      arb_owner, OWN_NONE);
    chk("rst_addr",       pmem_address, 0);
    chk("rst_wdata",      pmem_wdata, 0);
    pmem_resp = 1'b0;
    rst_n     = 1'b1;
    settle();
    chk("rel_owner_idle", arb_owner, OWN_NONE);
    cyc();
    chk("rel_owner_d", arb_owner, OWN_D);
    chk("rel_addr",    pmem_address, 16'h2222);
    pmem_resp = 1'b1;
    settle();
    chk("rel_dresp", dcache_pmem_resp, 1);
    chk("rel_iresp", icache_pmem_resp, 0);
    cyc();
    clear_inputs();

    // ---------------- lone icache read, resp 3 cycles later ----------------
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1230;
    settle();
    chk("i_c0_read",  pmem_read, 0);
    chk("i_c0_owner", arb_owner, OWN_NONE);
    cyc();
    chk("i_c1_read",  pmem_read, 1);
    chk("i_c1_write", pmem_write, 0);
    chk("i_c1_addr",  pmem_address, 16'h1230);
    chk("i_c1_owner", arb_owner, OWN_I);
    chk("i_c1_iresp", icache_pmem_resp, 0);
    cyc();
    chk("i_c2_addr",  pmem_address, 16'h1230);
    chk("i_c2_iresp", icache_pmem_resp, 0);
    cyc();
    rd         = {$urandom, $urandom, $urandom, $urandom};
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    settle();
    chk("i_c3_iresp", icache_pmem_resp, 1);
    chk("i_c3_dresp", dcache_pmem_resp, 0);
    chk("i_c3_rdata", icache_pmem_rdata, rd);
    chk("d_rdata_bc", dcache_pmem_rdata, rd);
    cyc();
    pmem_resp        = 1'b0;
    icache_pmem_read = 1'b0;
    settle();
    chk("i_c4_owner", arb_owner, OWN_NONE);
    chk("i_c4_read",  pmem_read, 0);

    // ---------------- simultaneous icache read / dcache write ----------------
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h0040;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h8000;
    dcache_pmem_wdata   = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    cyc();
    chk("both_owner_d", arb_owner, OWN_D);
    chk("both_write",   pmem_write, 1);
    chk("both_read",    pmem_read, 0);
    chk("both_addr_d",  pmem_address, 16'h8000);
    chk("both_wdata",   pmem_wdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    pmem_resp = 1'b1;
    settle();
    chk("both_dresp", dcache_pmem_resp, 1);
    chk("both_iresp", icache_pmem_resp, 0);
    cyc();
    pmem_resp         = 1'b0;
    dcache_pmem_write = 1'b0;
    settle();
    chk("both_bubble_owner", arb_owner, OWN_NONE);
    chk("both_bubble_write", pmem_write, 0);
    cyc();
    chk("both_owner_i", arb_owner, OWN_I);
    chk("both_addr_i",  pmem_address, 16'h0040);
    chk("both_read_i",  pmem_read, 1);
    pmem_resp = 1'b1;
    settle();
    chk("both_iresp2", icache_pmem_resp, 1);
    cyc();
    clear_inputs();

    // ---------------- starvation: continuous dcache with icache waiting ----------------
    do_reset();
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h0100;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h2000;
    first_i = -1;
    for (int g = 0; g < 2 * (LIMIT + 1); g++) begin
      win  = pick(1'b1, 1'b1, lost);
      lost = next_lost(1'b1, win, lost);
      cyc();
      chk($sformatf("starve_owner_%0d", g), arb_owner, win);
      if (arb_owner == OWN_I && first_i < 0) first_i = g;
      pmem_resp = 1'b1;
      settle();
      chk($sformatf("starve_resp_%0d", g),
          {icache_pmem_resp, dcache_pmem_resp}, (win == OWN_I) ? 2'b10 : 2'b01);
      cyc();
      pmem_resp = 1'b0;
    end
    chk("starve_first_i", first_i, LIMIT);
    clear_inputs();

    // ---------------- reset during SERVE_D, then a late resp ----------------
    do_reset();
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h4440;
    dcache_pmem_wdata   = {4{32'hA5A55A5A}};
    cyc();
    chk("abort_owner_d", arb_owner, OWN_D);
    chk("abort_write_d", pmem_write, 1);
    rst_n = 1'b0;
    cyc();
    chk("abort_owner", arb_owner, OWN_NONE);
    chk("abort_write", pmem_write, 0);
    chk("abort_wdata", pmem_wdata, 0);
    rst_n             = 1'b1;
    dcache_pmem_write = 1'b0;
    pmem_resp         = 1'b1;
    settle();
    chk("late_iresp", icache_pmem_resp, 0);
    chk("late_dresp", dcache_pmem_resp, 0);
    cyc();
    pmem_resp = 1'b0;
    chk("late_owner", arb_owner, OWN_NONE);

    // ---------------- back-to-back dcache reads ----------------
    do_reset();
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h3000;
    cyc();
    chk("b2b_read1", pmem_read, 1);
    chk("b2b_addr1", pmem_address, 16'h3000);
    cyc();
    pmem_resp = 1'b1;
    settle();
    chk("b2b_resp1", dcache_pmem_resp, 1);
    cyc();
    pmem_resp           = 1'b0;
    dcache_pmem_address = 16'h3010;
    settle();
    chk("b2b_gap_read",  pmem_read, 0);
    chk("b2b_gap_owner", arb_owner, OWN_NONE);
    cyc();
    chk("b2b_read2", pmem_read, 1);
    chk("b2b_addr2", pmem_address, 16'h3010);
    pmem_resp = 1'b1;
    cyc();
    clear_inputs();

    // ---------------- randomized traffic against the model ----------------
    do_reset();
    ipend = 1'b0;
    dpend = 1'b0;
    dwr   = 1'b0;
    ia    = '0;
    da    = '0;
    wd    = '0;
    for (int t = 0; t < 80; t++) begin
      if (!ipend && ($urandom_range(0, 1) == 1)) begin
        ipend = 1'b1;
        ia    = ADDR_W'($urandom);
      end
      if (!dpend && ($urandom_range(0, 2) != 0)) begin
        dpend = 1'b1;
        dwr   = bit'($urandom_range(0, 1));
        da    = ADDR_W'($urandom);
        wd    = {$urandom, $urandom, $urandom, $urandom};
      end
      icache_pmem_read    = ipend;
      icache_pmem_address = ia;
      dcache_pmem_read    = dpend && !dwr;
      dcache_pmem_write   = dpend && dwr;
      dcache_pmem_address = da;
      dcache_pmem_wdata   = wd;
      win  = pick(ipend, dpend, lost);
      lost = next_lost(ipend, win, lost);
      settle();
      chk("rnd_idle_owner", arb_owner, OWN_NONE);
      chk("rnd_idle_req",   {pmem_read, pmem_write}, 2'b00);
      cyc();
      chk("rnd_owner", arb_owner, win);
      if (win == OWN_NONE) continue;
      if (win == OWN_I) begin
        chk("rnd_i_rw",   {pmem_read, pmem_write}, 2'b10);
        chk("rnd_i_addr", pmem_address, ia);
      end else begin
        chk("rnd_d_rw",    {pmem_read, pmem_write}, {!dwr, dwr});
        chk("rnd_d_addr",  pmem_address, da);
        chk("rnd_d_wdata", pmem_wdata, wd);
      end
      lat = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        chk("rnd_wait_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
        cyc();
        chk("rnd_hold_owner", arb_owner, win);
      end
      rd         = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = rd;
      pmem_resp  = 1'b1;
      settle();
      chk("rnd_resp", {icache_pmem_resp, dcache_pmem_resp},
          (win == OWN_I) ? 2'b10 : 2'b01);
      chk("rnd_rdata", (win == OWN_I) ? icache_pmem_rdata : dcache_pmem_rdata, rd);
      if (win == OWN_I) ipend = 1'b0;
      else              dpend = 1'b0;
      cyc();
      pmem_resp = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
